// File: rtl/reg_writeback_pkg.sv
// Shared types and default widths for the per-thread register write-back sequencer.
package gpu_wb_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int NUM_GPR = 13;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_if.sv
// Handshake and register-file write port bundle; master is the execute/LSU side, slave is the sequencer.
interface reg_writeback_if #(
  parameter int DATA_W = gpu_wb_pkg::DATA_W,
  parameter int ADDR_W = gpu_wb_pkg::ADDR_W
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              illegal_write;
  logic              busy;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    input  alu_ready, lsu_ready,
    input  wr_en, wr_addr, wr_data, illegal_write, busy
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    output alu_ready, lsu_ready,
    output wr_en, wr_addr, wr_data, illegal_write, busy
  );

endinterface

// File: rtl/reg_writeback_fifo.sv
// Small synchronous FIFO of write-back entries buffering LSU load responses.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  gpu_wb_pkg::wb_entry_t din,
  input  logic                  pop,
  output gpu_wb_pkg::wb_entry_t head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);
  import gpu_wb_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths stay in range.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU results and buffered LSU responses into the register file's single write port,
// with a starvation guard for the LSU and suppression of writes to read-only registers.
module reg_writeback #(
  parameter int DATA_W     = gpu_wb_pkg::DATA_W,
  parameter int ADDR_W     = gpu_wb_pkg::ADDR_W,
  parameter int NUM_GPR    = gpu_wb_pkg::NUM_GPR,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic           clk,
  input  logic           reset,
  reg_writeback_if.slave bus
);
  import gpu_wb_pkg::*;

  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  wb_entry_t           fifo_head, lsu_entry, alu_entry, win_entry;
  logic                force_lsu, alu_fire;
  wb_src_e             src;

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                illegal_q, illegal_d;

  assign alu_entry = {bus.alu_addr, bus.alu_data};
  assign lsu_entry = {bus.lsu_addr, bus.lsu_data};

  // Ready toward the LSU comes from the registered count only, never from this cycle's pop.
  assign bus.lsu_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign fifo_push     = bus.lsu_valid && !fifo_full;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .din   (lsu_entry),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign force_lsu     = !fifo_empty && (starve_q == STARVE_W'(STARVE_MAX));
  assign bus.alu_ready = !force_lsu;
  assign alu_fire      = bus.alu_valid && !force_lsu;
  assign fifo_pop      = !fifo_empty && !alu_fire;

  always_comb begin
    src = SRC_NONE;
    if (alu_fire) begin
      src = SRC_ALU;
    end else if (fifo_pop) begin
      src = SRC_LSU;
    end
  end

  // The counter only climbs while an entry is waiting and the ALU keeps winning.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_pop) begin
      starve_d = '0;
    end else if (alu_fire && (starve_q != STARVE_W'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    wr_en_d   = 1'b0;
    illegal_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    win_entry = alu_entry;
    unique case (src)
      SRC_ALU: win_entry = alu_entry;
      SRC_LSU: win_entry = fifo_head;
      default: win_entry = alu_entry;
    endcase
    if (src != SRC_NONE) begin
      if (win_entry.addr < ADDR_W'(NUM_GPR)) begin
        wr_en_d   = 1'b1;
        wr_addr_d = win_entry.addr;
        wr_data_d = win_entry.data;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.wr_en         = wr_en_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.illegal_write = illegal_q;
  assign bus.busy          = !fifo_empty || wr_en_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed and randomized bench for reg_writeback against a queue-based reference model.
module tb_reg_writeback;
  import gpu_wb_pkg::*;

  localparam int FIFO_DEPTH = 2;
  localparam int STARVE_MAX = 3;

  logic clk;
  logic rst_n;

  reg_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_writeback #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_GPR    (NUM_GPR),
    .FIFO_DEPTH (FIFO_DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: pending LSU entries in a queue, wait length as a plain integer.
  wb_entry_t         m_q[$];
  int                m_starve;
  bit                m_wr_en;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [DATA_W-1:0] m_wr_data;
  bit                m_ill;
  bit                m_acc_alu;
  bit                m_acc_lsu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_starve  = 0;
    m_wr_en   = 0;
    m_wr_addr = '0;
    m_wr_data = '0;
    m_ill     = 0;
    m_acc_alu = 0;
    m_acc_lsu = 0;
  endtask

  task automatic check_outputs(input string when);
    chk({when, "_wr_en"},   32'(bus.wr_en),         32'(m_wr_en));
    chk({when, "_wr_addr"}, 32'(bus.wr_addr),       32'(m_wr_addr));
    chk({when, "_wr_data"}, 32'(bus.wr_data),       32'(m_wr_data));
    chk({when, "_illegal"}, 32'(bus.illegal_write), 32'(m_ill));
    chk({when, "_busy"},    32'(bus.busy),          32'((m_q.size() > 0) || m_wr_en));
  endtask

  // One clock: drive at edge+1, check readies, take the edge, update the model, check outputs.
  task automatic step(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input bit lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    bit        forced, exp_ar, exp_lr, was_empty, have;
    wb_entry_t w;
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
    bus.lsu_valid = lv;
    bus.lsu_addr  = la;
    bus.lsu_data  = ld;
    #1;
    forced = (m_starve == STARVE_MAX) && (m_q.size() > 0);
    exp_ar = !forced;
    exp_lr = (m_q.size() < FIFO_DEPTH);
    chk("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
    chk("lsu_ready", 32'(bus.lsu_ready), 32'(exp_lr));
    @(posedge clk);
    m_acc_alu = av && exp_ar;
    m_acc_lsu = lv && exp_lr;
    was_empty = (m_q.size() == 0);
    have      = 0;
    w         = '0;
    if (m_acc_alu) begin
      w    = {aa, ad};
      have = 1;
      if (!was_empty && m_starve < STARVE_MAX) m_starve++;
    end else if (!was_empty) begin
      w    = m_q.pop_front();
      have = 1;
    end
    if (was_empty || (have && !m_acc_alu)) m_starve = 0;
    if (m_acc_lsu) m_q.push_back({la, ld});
    m_ill   = have && (int'(w.addr) >= NUM_GPR);
    m_wr_en = have && (int'(w.addr) < NUM_GPR);
    if (m_wr_en) begin
      m_wr_addr = w.addr;
      m_wr_data = w.data;
    end
    #1;
    check_outputs("post");
  endtask

  task automatic idle();
    step(0, '0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    #1;
    model_clear();
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int                n4;
    bit                seen5;
    logic [DATA_W-1:0] d4;
    bit                p_av, p_lv;
    logic [ADDR_W-1:0] p_aa, p_la;
    logic [DATA_W-1:0] p_ad, p_ld;

    rst_n         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_addr  = '0;
    bus.alu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_addr  = '0;
    bus.lsu_data  = '0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("init_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("init_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    check_outputs("init");
    rst_n = 1'b1;

    // Single ALU write, visible for exactly one cycle.
    step(1, 4'd3, 8'hA5, 0, '0, '0);
    chk("alu_r3_en",   32'(bus.wr_en),   32'd1);
    chk("alu_r3_addr", 32'(bus.wr_addr), 32'd3);
    chk("alu_r3_data", 32'(bus.wr_data), 32'hA5);
    idle();
    chk("alu_r3_drop", 32'(bus.wr_en), 32'd0);

    // Two LSU responses with the ALU idle retire back to back.
    step(0, '0, '0, 1, 4'd1, 8'h11);
    step(0, '0, '0, 1, 4'd2, 8'h22);
    chk("lsu_r1_addr", 32'(bus.wr_addr), 32'd1);
    chk("lsu_r1_data", 32'(bus.wr_data), 32'h11);
    idle();
    chk("lsu_r2_addr", 32'(bus.wr_addr), 32'd2);
    chk("lsu_r2_data", 32'(bus.wr_data), 32'h22);
    idle();
    idle();

    // ALU hogging R4 while one load for R5 waits.
    d4 = 8'h40;
    step(1, 4'd4, d4, 1, 4'd5, 8'h55);
    d4++;
    n4    = 0;
    seen5 = 0;
    for (int i = 0; i < 10 && !seen5; i++) begin
      step(1, 4'd4, d4, 0, '0, '0);
      if (m_acc_alu) d4++;
      if (bus.wr_en && bus.wr_addr == 4'd5) seen5 = 1;
      else if (bus.wr_en && bus.wr_addr == 4'd4) n4++;
    end
    chk("starve_seen_r5",    32'(seen5), 32'd1);
    chk("starve_alu_writes", 32'(n4),    32'(STARVE_MAX));
    step(1, 4'd4, d4, 0, '0, '0);
    idle();

    // Write to a read-only register is dropped and flagged, the next one goes through.
    step(1, 4'd14, 8'h7F, 0, '0, '0);
    chk("ro_wr_en",  32'(bus.wr_en),         32'd0);
    chk("ro_illegal", 32'(bus.illegal_write), 32'd1);
    step(1, 4'd12, 8'h3C, 0, '0, '0);
    chk("r12_illegal", 32'(bus.illegal_write), 32'd0);
    chk("r12_addr",    32'(bus.wr_addr),       32'd12);
    idle();

    // Fill the buffer behind the ALU, then reset mid-operation.
    step(1, 4'd6, 8'h61, 1, 4'd7, 8'h71);
    step(1, 4'd6, 8'h62, 1, 4'd8, 8'h81);
    chk("full_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    do_reset();
    idle();
    chk("after_rst_busy",  32'(bus.busy),  32'd0);
    chk("after_rst_wr_en", 32'(bus.wr_en), 32'd0);
    idle();

    // Randomized traffic; sources hold their offer until it is taken.
    p_av = 0; p_lv = 0;
    p_aa = '0; p_la = '0; p_ad = '0; p_ld = '0;
    for (int c = 0; c < 500; c++) begin
      if (!p_av || m_acc_alu) begin
        p_av = ($urandom_range(0, 3) != 0);
        p_aa = 4'($urandom_range(0, 15));
        p_ad = 8'($urandom);
      end
      if (!p_lv || m_acc_lsu) begin
        p_lv = ($urandom_range(0, 1) != 0);
        p_la = 4'($urandom_range(0, 15));
        p_ld = 8'($urandom);
      end
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
        p_av = 0;
        p_lv = 0;
      end else begin
        step(p_av, p_aa, p_ad, p_lv, p_la, p_ld);
      end
    end
    idle();
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
